// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall scheduler for the 5-stage pipeline: load-use bubbles, MUL/DIV
// occupancy of EX, data-SRAM wait absorption and a saturating stall-cycle counter.
module pipe_stall_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic        id_rs_ren,
  input  logic [4:0]  id_rt,
  input  logic        id_rt_ren,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_rf_waddr,
  input  logic        ex_mdu_start,
  input  logic        ex_mdu_is_div,
  input  logic        mem_wait,
  output logic [5:0]  stall,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic        lu_stall,
  output logic [31:0] stall_cycles
);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LU   = 6'b000011;
  localparam logic [5:0] STALL_MDU  = 6'b000111;
  localparam logic [5:0] STALL_MEM  = 6'b001111;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             lu;
  logic             mdu_occ;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign lu = id_valid & ex_valid & ex_load & ex_rf_we & (ex_rf_waddr != 5'd0) &
              ((id_rs_ren & (id_rs == ex_rf_waddr)) | (id_rt_ren & (id_rt == ex_rf_waddr)));

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    mdu_busy = 1'b0;
    mdu_done = 1'b0;
    mdu_occ  = 1'b0;
    stall    = STALL_NONE;
    lu_stall = 1'b0;
    unique case (state)
      IDLE: begin
        if (ex_mdu_start) begin
          mdu_busy = 1'b1;
          mdu_occ  = 1'b1;
          cnt_d    = ex_mdu_is_div ? DIV_LOAD : MUL_LOAD;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        mdu_busy = 1'b1;
        if (cnt != '0) begin
          mdu_occ = 1'b1;
          cnt_d   = cnt - 1'b1;
        end else if (!mem_wait) begin
          mdu_done = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = DONE_WAIT;
        end
      end
      DONE_WAIT: begin
        mdu_busy = 1'b1;
        if (!mem_wait) begin
          mdu_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (mem_wait)     stall = STALL_MEM;
    else if (mdu_occ) stall = STALL_MDU;
    else if (lu) begin
      stall    = STALL_LU;
      lu_stall = 1'b1;
    end

    // Reset overrides every output and aborts any MUL/DIV in flight.
    if (rst) begin
      state_d  = IDLE;
      cnt_d    = '0;
      mdu_busy = 1'b0;
      mdu_done = 1'b0;
      stall    = STALL_NONE;
      lu_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (stall != STALL_NONE) stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule
